// File: rtl/blit_pkg.sv
// Shared types and widths for the blit RAM arbiter.
// Both requesters issue 18-bit byte addresses and move 16-bit data words.
package blit_pkg;

  localparam int BLIT_ADDR_W = 18;
  localparam int BLIT_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } blit_own_e;

endpackage

// File: rtl/blit_arb_pick.sv
// Grant selection: video has fixed priority over the CPU, except when the CPU
// has already waited through VID_MAX consecutive video grants.
module blit_arb_pick
  import blit_pkg::*;
#(
  parameter int VID_MAX = 4,
  parameter int VCNT_W  = 3
) (
  input  logic              cpu_req,
  input  logic              vid_req,
  input  logic [VCNT_W-1:0] vcnt,
  output logic              grant,
  output blit_own_e         owner
);

  localparam logic [VCNT_W-1:0] VCNT_MAX = VCNT_W'(VID_MAX);

  always_comb begin
    grant = 1'b0;
    owner = OWN_CPU;
    if (vid_req && !(cpu_req && (vcnt == VCNT_MAX))) begin
      grant = 1'b1;
      owner = OWN_VID;
    end else if (cpu_req) begin
      grant = 1'b1;
      owner = OWN_CPU;
    end
  end

endmodule

// File: rtl/blit_ram_arb.sv
// Arbiter sharing the blit RAM port between the CPU and the video fetcher.
// Every access is a fixed four-cycle sequence with a single-cycle ram_req pulse.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch the owner's access
// ISSUE | ram_req high for this one cycle
// WAIT  | waiting for ram_ack; capture ram_rdata for the owner
// DONE  | owner's ack pulse
module blit_ram_arb
  import blit_pkg::*;
#(
  parameter int VID_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cpu_req,
  input  logic [BLIT_ADDR_W-1:0] cpu_addr,
  input  logic                   cpu_we,
  input  logic [BLIT_DATA_W-1:0] cpu_wdata,
  input  logic [1:0]             cpu_wstrb,
  output logic                   cpu_ack,
  output logic [BLIT_DATA_W-1:0] cpu_rdata,
  input  logic                   vid_req,
  input  logic [BLIT_ADDR_W-1:0] vid_addr,
  output logic                   vid_ack,
  output logic [BLIT_DATA_W-1:0] vid_rdata,
  output logic                   ram_req,
  output logic [BLIT_ADDR_W-1:0] ram_addr,
  output logic [BLIT_DATA_W-1:0] ram_wdata,
  output logic [1:0]             ram_wstrb,
  output logic                   ram_we,
  input  logic                   ram_ack,
  input  logic [BLIT_DATA_W-1:0] ram_rdata
);

  localparam int VCNT_W = (VID_MAX < 1) ? 1 : $clog2(VID_MAX + 1);
  localparam logic [VCNT_W-1:0] VCNT_MAX = VCNT_W'(VID_MAX);

  blit_state_e       state, state_nxt;
  blit_own_e         own;
  logic [VCNT_W-1:0] vcnt;
  logic              grant;
  blit_own_e         pick_own;

  blit_arb_pick #(
    .VID_MAX(VID_MAX),
    .VCNT_W (VCNT_W)
  ) u_pick (
    .cpu_req(cpu_req),
    .vid_req(vid_req),
    .vcnt   (vcnt),
    .grant  (grant),
    .owner  (pick_own)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ram_ack) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so they are glitch-free
  // and fall to their reset values the moment rstn asserts.
  assign ram_req = (state == ST_ISSUE);
  assign cpu_ack = (state == ST_DONE) && (own == OWN_CPU);
  assign vid_ack = (state == ST_DONE) && (own == OWN_VID);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      own       <= OWN_CPU;
      vcnt      <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wstrb <= '0;
      ram_we    <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (grant) begin
          own <= pick_own;
          if (pick_own == OWN_VID) begin
            ram_addr  <= vid_addr;
            ram_we    <= 1'b0;
            ram_wstrb <= 2'b00;
          end else begin
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
            ram_wstrb <= cpu_wstrb;
            ram_we    <= cpu_we;
          end
        end
        // vcnt tracks video grants taken while the CPU was kept waiting
        if (!cpu_req) begin
          vcnt <= '0;
        end else if (grant && (pick_own == OWN_CPU)) begin
          vcnt <= '0;
        end else if (grant && (vcnt != VCNT_MAX)) begin
          vcnt <= vcnt + VCNT_W'(1);
        end
      end
      if ((state == ST_WAIT) && ram_ack) begin
        if (own == OWN_CPU) cpu_rdata <= ram_rdata;
        else                vid_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_blit_ram_arb.sv
// Self-checking bench for blit_ram_arb: directed vector table, multi-cycle
// corner cases, and randomized traffic against a reference memory.
module tb_blit_ram_arb;

  localparam int VID_MAX = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [1:0]  cpu_wstrb = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        vid_req = 1'b0;
  logic [17:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        ram_req, ram_we, ram_ack;
  logic [17:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [1:0]  ram_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  blit_ram_arb #(.VID_MAX(VID_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_we(ram_we),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata)
  );

  // RAM model: one access per cycle with ram_req high, ack one cycle later.
  // It is never reset, so an in-flight access still acks after rstn drops.
  logic [15:0] mem [0:131071];
  logic        model_ack = 1'b0;
  logic        inj_ack = 1'b0;
  logic [15:0] model_rdata = '0;
  assign ram_ack   = model_ack | inj_ack;
  assign ram_rdata = model_rdata;

  initial for (int i = 0; i < 131072; i++) mem[i] = '0;

  always @(posedge clk) begin
    model_ack <= ram_req;
    if (ram_req) begin
      model_rdata <= mem[ram_addr[17:1]];
      if (ram_we) begin
        if (ram_wstrb[0]) mem[ram_addr[17:1]][7:0]  <= ram_wdata[7:0];
        if (ram_wstrb[1]) mem[ram_addr[17:1]][15:8] <= ram_wdata[15:8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Protocol monitor: no back-to-back ram_req, video accesses never write.
  bit prev_req = 1'b0, pend_valid = 1'b0, pend_we = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_req = 1'b0;
      pend_valid = 1'b0;
    end else begin
      if (ram_req) begin
        check("ram_req_gap", {31'd0, prev_req}, 32'd0);
        pend_we = ram_we;
        pend_valid = 1'b1;
      end
      if (vid_ack && pend_valid) check("vid_we_zero", {31'd0, pend_we}, 32'd0);
      prev_req = ram_req;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_req"},   {31'd0, ram_req}, 0);
    check({tag, "_ram_we"},    {31'd0, ram_we}, 0);
    check({tag, "_ram_wstrb"}, {30'd0, ram_wstrb}, 0);
    check({tag, "_ram_addr"},  {14'd0, ram_addr}, 0);
    check({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 0);
    check({tag, "_acks"},      {30'd0, cpu_ack, vid_ack}, 0);
    check({tag, "_cpu_rdata"}, {16'd0, cpu_rdata}, 0);
    check({tag, "_vid_rdata"}, {16'd0, vid_rdata}, 0);
  endtask

  // One access on one port; reports ack cycle, ram_req cycles and field stability.
  task automatic do_access(input bit vid, input bit we, input logic [17:0] addr,
                           input logic [15:0] wdata, input logic [1:0] wstrb,
                           output logic [15:0] rdata, output int lat,
                           output int nreq, output int req_at, output bit fields_ok);
    logic [1:0] exp_strb;
    bit         exp_we;
    exp_we   = we && !vid;
    exp_strb = vid ? 2'b00 : wstrb;
    @(posedge clk); #1;
    if (vid) begin
      vid_req = 1'b1; vid_addr = addr;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    end
    lat = -1; nreq = 0; req_at = -1; fields_ok = 1'b1; rdata = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_req) begin
        nreq++;
        if (req_at < 0) req_at = c;
      end
      if (c >= 1 && (ram_addr !== addr || ram_we !== exp_we || ram_wstrb !== exp_strb ||
                     (exp_we && ram_wdata !== wdata)))
        fields_ok = 1'b0;
      if (vid ? vid_ack : cpu_ack) begin
        lat = c;
        rdata = vid ? vid_rdata : cpu_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    if (vid) vid_req = 1'b0;
    else     cpu_req = 1'b0;
  endtask

  typedef struct {
    bit          vid;
    bit          we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 16'h0000;
  endfunction

  task automatic cpu_agent(input int n);
    bit          we, got;
    logic [17:0] a;
    logic [15:0] d, old;
    logic [1:0]  s;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      we = $urandom_range(0, 1); a = 18'h08000 + 18'($urandom_range(0, 15));
      d = 16'($urandom); s = 2'($urandom_range(0, 3));
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (cpu_ack) begin got = 1'b1; break; end
      end
      check("rand_cpu_ack_seen", {31'd0, got}, 1);
      if (got) begin
        old = ref_rd(int'(a[17:1]));
        if (we) begin
          if (s[0]) old[7:0] = d[7:0];
          if (s[1]) old[15:8] = d[15:8];
          ref_mem[int'(a[17:1])] = old;
        end else begin
          check("rand_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, old});
        end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
    end
  endtask

  task automatic vid_agent(input int n);
    bit          got;
    logic [17:0] a;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      a = 18'h08000 + 18'($urandom_range(0, 15));
      vid_req = 1'b1; vid_addr = a;
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (vid_ack) begin got = 1'b1; break; end
      end
      check("rand_vid_ack_seen", {31'd0, got}, 1);
      if (got) check("rand_vid_rdata", {16'd0, vid_rdata}, {16'd0, ref_rd(int'(a[17:1]))});
      @(posedge clk); #1;
      vid_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int          lat, nreq, req_at, n, first_ack, ack_cnt, streak;
    bit          fok;
    bit          got_c [10];
    int          got_cyc [10];
    bit          exp_c;

    vecs[0]  = '{0, 1, 18'h00100, 16'hBEEF, 2'd3, 16'h0000};
    vecs[1]  = '{0, 0, 18'h00100, 16'h0000, 2'd0, 16'hBEEF};
    vecs[2]  = '{1, 0, 18'h00100, 16'h0000, 2'd0, 16'hBEEF};
    vecs[3]  = '{0, 1, 18'h00100, 16'h1234, 2'd2, 16'h0000};
    vecs[4]  = '{0, 0, 18'h00100, 16'h0000, 2'd0, 16'h12EF};
    vecs[5]  = '{0, 1, 18'h00101, 16'h00AA, 2'd1, 16'h0000};
    vecs[6]  = '{1, 0, 18'h00101, 16'h0000, 2'd0, 16'h12AA};
    vecs[7]  = '{0, 1, 18'h3FFFE, 16'h5A5A, 2'd3, 16'h0000};
    vecs[8]  = '{0, 0, 18'h3FFFE, 16'h0000, 2'd0, 16'h5A5A};
    vecs[9]  = '{0, 1, 18'h00100, 16'hFFFF, 2'd0, 16'h0000};
    vecs[10] = '{0, 0, 18'h00100, 16'h0000, 2'd0, 16'h12AA};

    #2;
    check_reset_outputs("reset0");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset1");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      do_access(vecs[i].vid, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                rd, lat, nreq, req_at, fok);
      check($sformatf("vec%0d_ack_cycle", i), lat, 3);
      check($sformatf("vec%0d_req_cycle", i), req_at, 1);
      check($sformatf("vec%0d_req_count", i), nreq, 1);
      check($sformatf("vec%0d_ram_fields", i), {31'd0, fok}, 1);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp});
    end

    // Both requests held continuously: expected order from the starvation rule
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00100;
    vid_req = 1'b1; vid_addr = 18'h3FFFE;
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) begin
        got_c[n] = cpu_ack; got_cyc[n] = c; n++;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; vid_req = 1'b0;
    check("arb_ack_count", n, 10);
    streak = 0;
    for (int i = 0; i < n; i++) begin
      exp_c = (streak == VID_MAX);
      streak = exp_c ? 0 : streak + 1;
      check($sformatf("arb_owner%0d_is_cpu", i), {31'd0, got_c[i]}, {31'd0, exp_c});
      check($sformatf("arb_cycle%0d", i), got_cyc[i], 3 + 4 * i);
    end

    // Reset during WAIT while ram_ack arrives
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0; cpu_req = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rstn = 1'b1;
    ack_cnt = 0;
    repeat (6) begin @(negedge clk); if (cpu_ack || vid_ack) ack_cnt++; end
    check("rst_wait_no_ack", ack_cnt, 0);
    do_access(0, 0, 18'h00100, 16'h0, 2'd0, rd, lat, nreq, req_at, fok);
    check("post_rst_ack_cycle", lat, 3);
    check("post_rst_rdata", {16'd0, rd}, 32'h12AA);

    // Spurious ram_ack in IDLE
    @(posedge clk); #1;
    inj_ack = 1'b1;
    @(posedge clk); #1;
    inj_ack = 1'b0;
    ack_cnt = 0;
    repeat (4) begin @(negedge clk); if (cpu_ack || vid_ack || ram_req) ack_cnt++; end
    check("spur_idle_quiet", ack_cnt, 0);

    // Spurious ram_ack during ISSUE: access timing must be unchanged
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h3FFFE;
    first_ack = -1;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) inj_ack = 1'b1;
      if (c == 2) inj_ack = 1'b0;
      @(negedge clk);
      if (cpu_ack && first_ack < 0) begin first_ack = c; rd = cpu_rdata; end
      @(posedge clk); #1;
      if (first_ack >= 0) cpu_req = 1'b0;
    end
    check("spur_issue_ack_cycle", first_ack, 3);
    check("spur_issue_rdata", {16'd0, rd}, 32'h5A5A);

    // Randomized concurrent traffic
    repeat (2) begin @(posedge clk); #1; end
    fork
      cpu_agent(60);
      vid_agent(60);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
